// File: rtl/mem_arbiter_pkg.sv
// Shared memory-operation encodings used by the control unit and the memory arbiter.
package mem_arbiter_pkg;

    localparam int MEM_OP_BITS = 2;

    localparam logic [MEM_OP_BITS-1:0] MEM_OP_NOP   = 2'd0;
    localparam logic [MEM_OP_BITS-1:0] MEM_OP_READ  = 2'd1;
    localparam logic [MEM_OP_BITS-1:0] MEM_OP_WRITE = 2'd2;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between instruction fetch and data accesses.
// Data wins by default, but fetch is forced through after STARVE_LIMIT data grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   if_req,
    input  logic [ADDR_W-1:0]      if_addr,
    output logic                   if_ack,
    output logic [DATA_W-1:0]      if_rdata,
    input  logic [MEM_OP_BITS-1:0] d_op,
    input  logic [ADDR_W-1:0]      d_addr,
    input  logic [DATA_W-1:0]      d_wdata,
    output logic                   d_ack,
    output logic [DATA_W-1:0]      d_rdata,
    output logic [MEM_OP_BITS-1:0] mem_op,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic                   mem_ack,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   stall
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [MEM_OP_BITS-1:0] memOp_q, memOp_d;
    logic [ADDR_W-1:0]      memAddr_q, memAddr_d;
    logic [DATA_W-1:0]      memWdata_q, memWdata_d;
    logic [CNT_W-1:0]       starveCnt_q, starveCnt_d;

    logic dataPending;
    logic fetchStarved;

    assign dataPending  = (d_op != MEM_OP_NOP);
    assign fetchStarved = if_req && (starveCnt_q == CNT_W'(STARVE_LIMIT));

    // Commands are latched only at grant so requester changes mid-transaction never reach memory.
    always_comb begin
        state_d     = state_q;
        memOp_d     = memOp_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        starveCnt_d = starveCnt_q;
        unique case (state_q)
            IDLE: begin
                if (dataPending && !fetchStarved) begin
                    state_d     = D_BUSY;
                    memOp_d     = d_op;
                    memAddr_d   = d_addr;
                    memWdata_d  = d_wdata;
                    // fetchStarved excludes the limit here, so the increment cannot overflow.
                    starveCnt_d = if_req ? starveCnt_q + CNT_W'(1) : '0;
                end else if (if_req) begin
                    state_d     = IF_BUSY;
                    memOp_d     = MEM_OP_READ;
                    memAddr_d   = if_addr;
                    starveCnt_d = '0;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    memOp_d = MEM_OP_NOP;
                end
            end
            default: begin
                state_d = IDLE;
                memOp_d = MEM_OP_NOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            memOp_q     <= MEM_OP_NOP;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            starveCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            memOp_q     <= memOp_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            starveCnt_q <= starveCnt_d;
        end
    end

    // Acks are masked while reset is high so an abandoned transaction never completes.
    assign if_ack    = (state_q == IF_BUSY) && mem_ack && !reset;
    assign d_ack     = (state_q == D_BUSY) && mem_ack && !reset;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign mem_op    = memOp_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign stall     = dataPending && !d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: grant latency, starvation limit,
// command hold, reset abandonment and same-cycle acks.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic                   clk;
    logic                   reset;
    logic                   if_req;
    logic [15:0]            if_addr;
    logic                   if_ack;
    logic [31:0]            if_rdata;
    logic [MEM_OP_BITS-1:0] d_op;
    logic [15:0]            d_addr;
    logic [31:0]            d_wdata;
    logic                   d_ack;
    logic [31:0]            d_rdata;
    logic [MEM_OP_BITS-1:0] mem_op;
    logic [15:0]            mem_addr;
    logic [31:0]            mem_wdata;
    logic                   mem_ack;
    logic [31:0]            mem_rdata;
    logic                   stall;

    int compared;
    int mismatched;

    mem_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
    task automatic applyStimulus(input logic [MEM_OP_BITS-1:0] op, input logic [15:0] dAddr,
                                 input logic [31:0] wdata, input logic ifReq, input logic ack);
        d_op    = op;
        d_addr  = dAddr;
        d_wdata = wdata;
        if_req  = ifReq;
        mem_ack = ack;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        if_addr    = 16'h0000;
        mem_rdata  = 32'h0;
        applyStimulus(MEM_OP_NOP, 16'h0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        reset = 1'b0;
        #1;
        checkOutput("rst_mem_op", 32'(mem_op), 32'(MEM_OP_NOP));
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst_stall", 32'(stall), 32'h0);

        // Lone data read, ack on the second busy cycle.
        applyStimulus(MEM_OP_READ, 16'h0010, 32'h0, 1'b0, 1'b0);
        checkOutput("a_stall_req", 32'(stall), 32'h1);
        checkOutput("a_idle_nop", 32'(mem_op), 32'(MEM_OP_NOP));
        nextCycle();
        checkOutput("a_mem_op", 32'(mem_op), 32'(MEM_OP_READ));
        checkOutput("a_mem_addr", 32'(mem_addr), 32'h0010);
        checkOutput("a_no_ack1", 32'(d_ack), 32'h0);
        nextCycle();
        checkOutput("a_hold_op", 32'(mem_op), 32'(MEM_OP_READ));
        checkOutput("a_stall_busy", 32'(stall), 32'h1);
        mem_rdata = 32'h12345678;
        applyStimulus(MEM_OP_READ, 16'h0010, 32'h0, 1'b0, 1'b1);
        checkOutput("a_d_ack", 32'(d_ack), 32'h1);
        checkOutput("a_d_rdata", d_rdata, 32'h12345678);
        checkOutput("a_stall_ack", 32'(stall), 32'h0);
        nextCycle();
        applyStimulus(MEM_OP_NOP, 16'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("a_back_nop", 32'(mem_op), 32'(MEM_OP_NOP));
        checkOutput("a_d_ack_once", 32'(d_ack), 32'h0);

        // Simultaneous fetch and write: data first, fetch after one bubble.
        if_addr = 16'h0100;
        applyStimulus(MEM_OP_WRITE, 16'h0020, 32'hDEADBEEF, 1'b1, 1'b0);
        nextCycle();
        checkOutput("b_mem_op", 32'(mem_op), 32'(MEM_OP_WRITE));
        checkOutput("b_mem_addr", 32'(mem_addr), 32'h0020);
        checkOutput("b_mem_wdata", mem_wdata, 32'hDEADBEEF);
        applyStimulus(MEM_OP_WRITE, 16'h0020, 32'hDEADBEEF, 1'b1, 1'b1);
        checkOutput("b_d_ack", 32'(d_ack), 32'h1);
        checkOutput("b_if_ack_low", 32'(if_ack), 32'h0);
        nextCycle();
        applyStimulus(MEM_OP_NOP, 16'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("b_bubble", 32'(mem_op), 32'(MEM_OP_NOP));
        nextCycle();
        checkOutput("b_fetch_op", 32'(mem_op), 32'(MEM_OP_READ));
        checkOutput("b_fetch_addr", 32'(mem_addr), 32'h0100);
        checkOutput("b_wdata_held", mem_wdata, 32'hDEADBEEF);
        mem_rdata = 32'hCAFEF00D;
        applyStimulus(MEM_OP_NOP, 16'h0, 32'h0, 1'b1, 1'b1);
        checkOutput("b_if_ack", 32'(if_ack), 32'h1);
        checkOutput("b_if_rdata", if_rdata, 32'hCAFEF00D);
        nextCycle();
        applyStimulus(MEM_OP_NOP, 16'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("b_back_nop", 32'(mem_op), 32'(MEM_OP_NOP));

        // Fetch held through five data ops: four data grants, then the fetch, then the fifth.
        if_addr = 16'h0200;
        applyStimulus(MEM_OP_READ, 16'h0300, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            checkOutput($sformatf("c_data%0d_addr", k), 32'(mem_addr), 32'h0300 + 32'(k));
            applyStimulus(MEM_OP_READ, 16'h0300 + 16'(k), 32'h0, 1'b1, 1'b1);
            checkOutput($sformatf("c_data%0d_ack", k), 32'(d_ack), 32'h1);
            nextCycle();
            applyStimulus(MEM_OP_READ, 16'h0301 + 16'(k), 32'h0, 1'b1, 1'b0);
            checkOutput($sformatf("c_data%0d_bubble", k), 32'(mem_op), 32'(MEM_OP_NOP));
        end
        nextCycle();
        checkOutput("c_fetch_addr", 32'(mem_addr), 32'h0200);
        checkOutput("c_fetch_stall", 32'(stall), 32'h1);
        applyStimulus(MEM_OP_READ, 16'h0304, 32'h0, 1'b1, 1'b1);
        checkOutput("c_fetch_ack", 32'(if_ack), 32'h1);
        checkOutput("c_no_d_ack", 32'(d_ack), 32'h0);
        nextCycle();
        applyStimulus(MEM_OP_READ, 16'h0304, 32'h0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("c_last_op", 32'(mem_op), 32'(MEM_OP_READ));
        checkOutput("c_last_addr", 32'(mem_addr), 32'h0304);
        applyStimulus(MEM_OP_READ, 16'h0304, 32'h0, 1'b0, 1'b1);
        checkOutput("c_last_ack", 32'(d_ack), 32'h1);
        nextCycle();
        applyStimulus(MEM_OP_NOP, 16'h0, 32'h0, 1'b0, 1'b0);

        // Requester address changes while busy must not reach memory.
        applyStimulus(MEM_OP_READ, 16'h0030, 32'h0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("d_addr_grant", 32'(mem_addr), 32'h0030);
        applyStimulus(MEM_OP_READ, 16'h0040, 32'h0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("d_addr_hold1", 32'(mem_addr), 32'h0030);
        nextCycle();
        checkOutput("d_addr_hold2", 32'(mem_addr), 32'h0030);
        applyStimulus(MEM_OP_READ, 16'h0040, 32'h0, 1'b0, 1'b1);
        checkOutput("d_ack", 32'(d_ack), 32'h1);
        nextCycle();
        applyStimulus(MEM_OP_NOP, 16'h0, 32'h0, 1'b0, 1'b0);

        // Ack in the first busy cycle; a stray ack in IDLE is ignored.
        applyStimulus(MEM_OP_WRITE, 16'h0050, 32'h00000011, 1'b0, 1'b0);
        nextCycle();
        checkOutput("e_mem_op", 32'(mem_op), 32'(MEM_OP_WRITE));
        applyStimulus(MEM_OP_WRITE, 16'h0050, 32'h00000011, 1'b0, 1'b1);
        checkOutput("e_first_ack", 32'(d_ack), 32'h1);
        nextCycle();
        applyStimulus(MEM_OP_NOP, 16'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("e_idle_next", 32'(mem_op), 32'(MEM_OP_NOP));
        checkOutput("e_idle_d_ack", 32'(d_ack), 32'h0);
        checkOutput("e_idle_if_ack", 32'(if_ack), 32'h0);
        nextCycle();
        applyStimulus(MEM_OP_NOP, 16'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("e_stray_ignored", 32'(mem_op), 32'(MEM_OP_NOP));

        // Reset mid-transaction, then a late ack that must be ignored.
        applyStimulus(MEM_OP_READ, 16'h0060, 32'h0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("f_mem_op", 32'(mem_op), 32'(MEM_OP_READ));
        reset = 1'b1;
        #1;
        nextCycle();
        checkOutput("f_rst_op", 32'(mem_op), 32'(MEM_OP_NOP));
        checkOutput("f_rst_addr", 32'(mem_addr), 32'h0);
        reset = 1'b0;
        applyStimulus(MEM_OP_NOP, 16'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("f_late_ack", 32'(d_ack), 32'h0);
        nextCycle();
        applyStimulus(MEM_OP_READ, 16'h0070, 32'h0, 1'b0, 1'b0);
        checkOutput("f_still_idle", 32'(mem_op), 32'(MEM_OP_NOP));
        nextCycle();
        checkOutput("f_regrant_addr", 32'(mem_addr), 32'h0070);
        reset = 1'b1;
        applyStimulus(MEM_OP_READ, 16'h0070, 32'h0, 1'b0, 1'b1);
        checkOutput("f_rst_ack_masked", 32'(d_ack), 32'h0);
        nextCycle();
        checkOutput("f_rst_prio_op", 32'(mem_op), 32'(MEM_OP_NOP));
        reset = 1'b0;
        applyStimulus(MEM_OP_NOP, 16'h0, 32'h0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("f_final_idle", 32'(mem_op), 32'(MEM_OP_NOP));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 16, address width; DATA_W, default 32, data width; STARVE_LIMIT, default 4, consecutive data grants tolerated while fetch waits.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: if_req  in  1  fetch read request, level-held until if_ack.
REQ-005 SHALL have ports: if_addr  in  ADDR_W  fetch address.
REQ-006 SHALL have ports: if_ack  out  1  fetch done; if_rdata  out  DATA_W  fetch read data, valid with if_ack.
REQ-007 SHALL have ports: d_op  in  MEM_OP_BITS  data op (MEM_OP_NOP/READ/WRITE), held until d_ack.
REQ-008 SHALL have ports: d_addr  in  ADDR_W; d_wdata  in  DATA_W; d_ack  out  1; d_rdata  out  DATA_W, valid with d_ack.
REQ-009 SHALL have ports: mem_op  out  MEM_OP_BITS; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  (registered memory command).
REQ-010 SHALL have ports: mem_ack  in  1  memory completion; mem_rdata  in  DATA_W.
REQ-011 SHALL have ports: stall  out  1  pipeline stall while a data op is pending.

Function
REQ-012 SHALL implement FSM states IDLE, IF_BUSY, D_BUSY.
REQ-013 SHALL, in IDLE with d_op!=NOP, grant data (go D_BUSY) unless if_req=1 and starve_cnt==STARVE_LIMIT, in which case grant fetch (go IF_BUSY).
REQ-014 SHALL, in IDLE with d_op==NOP and if_req=1, grant fetch.
REQ-015 SHALL register mem_op/mem_addr/mem_wdata at grant; command visible the cycle after the IDLE decision (1-cycle grant latency).
REQ-016 SHALL hold mem_op/mem_addr/mem_wdata constant throughout a BUSY state, ignoring requester input changes.
REQ-017 SHALL drive mem_op=MEM_OP_READ for fetch grants; mem_wdata don't-care but held.
REQ-018 SHALL drive mem_op=MEM_OP_NOP in IDLE.
REQ-019 SHALL accept mem_ack in any BUSY cycle, including the first; mem_ack in IDLE ignored.
REQ-020 SHALL assert if_ack=(state==IF_BUSY)&mem_ack and d_ack=(state==D_BUSY)&mem_ack combinationally; rdata outputs pass mem_rdata through.
REQ-021 SHALL return to IDLE on the cycle after mem_ack; one idle bubble between back-to-back transactions.
REQ-022 SHALL increment starve_cnt (saturating at STARVE_LIMIT) on each data grant made while if_req=1; clear it on fetch grant or on data grant with if_req=0.
REQ-023 SHALL drive stall=(d_op!=NOP)&~d_ack.
REQ-024 SHALL treat d_op=MEM_OP_WRITE identically to READ for arbitration; d_rdata undefined on write ack.

Reset
REQ-025 SHALL, on reset, force state=IDLE, mem_op=MEM_OP_NOP, mem_addr=0, mem_wdata=0, starve_cnt=0.
REQ-026 SHALL, when reset asserts mid-transaction, abandon it: no ack issued; mem_ack arriving after reset ignored.
REQ-027 SHALL give reset priority over mem_ack and new requests in the same cycle.

Structure
REQ-028 SHALL take MEM_OP_* encodings and MEM_OP_BITS from the shared defines package used by the control unit; FSM state encodings local.
REQ-029 SHALL be a single module, no sub-modules.

Verification
REQ-030 SHALL cover: d_op=READ addr 0x0010 alone, mem_ack 2 cycles after grant -> mem_op=READ 1 cycle after request, d_ack for exactly 1 cycle, stall high until d_ack.
REQ-031 SHALL cover: if_req and d_op=WRITE addr 0x0020 wdata 0xDEADBEEF same cycle -> data granted first, mem_wdata=0xDEADBEEF; fetch granted after ack plus 1 bubble.
REQ-032 SHALL cover: if_req held, 5 back-to-back data ops -> 4 data grants, then fetch grant, then remaining data op.
REQ-033 SHALL cover: reset asserted during D_BUSY with mem_ack next cycle -> mem_op=NOP, no d_ack, state IDLE.
REQ-034 SHALL cover: d_addr changed 0x0030->0x0040 during D_BUSY -> mem_addr stays 0x0030 until ack.
REQ-035 SHALL cover: mem_ack same cycle mem_op first non-NOP -> ack accepted, IDLE next cycle.
